// File: rtl/pmsm_solver_sequencer_if.sv
// Solver-side control/status bundle between the sequencer (master) and the
// PMSM state solver (slave).
interface pmsm_solver_sequencer_if #(
   parameter int W = 35
);
   logic                sol_enable;
   logic                sol_trigger;
   logic                sol_load;
   logic                sol_update_param;
   logic                sol_param_ready;
   logic                sol_valid;
   logic signed [W-1:0] sol_id;
   logic signed [W-1:0] sol_iq;
   logic signed [W-1:0] sol_omega;
   logic signed [W-1:0] sol_theta;

   modport master (
      output sol_enable,
      output sol_trigger,
      output sol_load,
      output sol_update_param,
      input  sol_param_ready,
      input  sol_valid,
      input  sol_id,
      input  sol_iq,
      input  sol_omega,
      input  sol_theta
   );

   modport slave (
      input  sol_enable,
      input  sol_trigger,
      input  sol_load,
      input  sol_update_param,
      output sol_param_ready,
      output sol_valid,
      output sol_id,
      output sol_iq,
      output sol_omega,
      output sol_theta
   );
endinterface

// File: rtl/pmsm_solver_sequencer.sv
// Host-side sequencer for the PMSM state solver: paces trigger/valid steps
// from a period timer, snapshots each result and guards the solver with a watchdog.
module pmsm_solver_sequencer #(
   parameter int W       = 35,
   parameter int TIMER_W = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                stop,
   input  logic                load_req,
   input  logic                param_req,
   input  logic                clr_err,
   input  logic [TIMER_W-1:0]  period,
   input  logic [31:0]         n_steps,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [31:0]         step_cnt,
   pmsm_solver_sequencer_if.master sol,
   output logic signed [W-1:0] snap_id,
   output logic signed [W-1:0] snap_iq,
   output logic signed [W-1:0] snap_omega,
   output logic signed [W-1:0] snap_theta,
   output logic                snap_valid
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PARAM,
      S_WAIT_TICK,
      S_TRIG,
      S_WAIT_VALID,
      S_ERR
   } state_t;

   state_t              state_q,        state_d;
   logic [TIMER_W-1:0]  timer_q,        timer_d;
   logic [WD_W-1:0]     wd_q,           wd_d;
   logic                stop_seen_q,    stop_seen_d;
   logic [31:0]         step_cnt_q,     step_cnt_d;
   logic signed [W-1:0] snap_id_q,      snap_id_d;
   logic signed [W-1:0] snap_iq_q,      snap_iq_d;
   logic signed [W-1:0] snap_omega_q,   snap_omega_d;
   logic signed [W-1:0] snap_theta_q,   snap_theta_d;
   logic                snap_valid_q,   snap_valid_d;
   logic                done_q,         done_d;
   logic                error_q,        error_d;
   logic                busy_q,         busy_d;
   logic                sol_enable_q,   sol_enable_d;
   logic                sol_trigger_q,  sol_trigger_d;
   logic                sol_load_q,     sol_load_d;
   logic                sol_upd_q,      sol_upd_d;

   logic [TIMER_W-1:0]  period_eff;
   logic [31:0]         step_cnt_inc;
   logic                wd_expired;

   assign period_eff   = (period == '0) ? TIMER_W'(1) : period;
   assign step_cnt_inc = step_cnt_q + 32'd1;
   assign wd_expired   = (wd_q == WD_W'(TIMEOUT));

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      wd_d         = wd_q;
      stop_seen_d  = stop_seen_q;
      step_cnt_d   = step_cnt_q;
      snap_id_d    = snap_id_q;
      snap_iq_d    = snap_iq_q;
      snap_omega_d = snap_omega_q;
      snap_theta_d = snap_theta_q;
      snap_valid_d = 1'b0;
      done_d       = 1'b0;
      error_d      = error_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               step_cnt_d  = '0;
               timer_d     = period_eff;
               stop_seen_d = 1'b0;
               state_d     = S_WAIT_TICK;
            end else if (param_req) begin
               wd_d    = '0;
               state_d = S_PARAM;
            end else if (load_req) begin
               state_d = S_LOAD;
            end
         end

         S_LOAD: begin
            state_d = S_IDLE;
         end

         S_PARAM: begin
            if (sol.sol_param_ready) begin
               state_d = S_IDLE;
            end else if (wd_expired) begin
               error_d = 1'b1;
               state_d = S_ERR;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end

         S_WAIT_TICK: begin
            // stop wins over an expiring timer so no trigger escapes
            if (stop) begin
               state_d = S_IDLE;
            end else if (timer_q <= TIMER_W'(1)) begin
               state_d = S_TRIG;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end

         S_TRIG: begin
            wd_d = '0;
            if (stop) begin
               stop_seen_d = 1'b1;
            end
            state_d = S_WAIT_VALID;
         end

         S_WAIT_VALID: begin
            if (sol.sol_valid) begin
               snap_id_d    = sol.sol_id;
               snap_iq_d    = sol.sol_iq;
               snap_omega_d = sol.sol_omega;
               snap_theta_d = sol.sol_theta;
               snap_valid_d = 1'b1;
               step_cnt_d   = step_cnt_inc;
               if ((n_steps != '0) && (step_cnt_inc == n_steps)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else if (stop_seen_q || stop) begin
                  state_d = S_IDLE;
               end else begin
                  timer_d = period_eff;
                  state_d = S_WAIT_TICK;
               end
            end else begin
               if (stop) begin
                  stop_seen_d = 1'b1;
               end
               if (wd_expired) begin
                  error_d = 1'b1;
                  state_d = S_ERR;
               end else begin
                  wd_d = wd_q + 1'b1;
               end
            end
         end

         S_ERR: begin
            if (clr_err) begin
               error_d = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Solver controls are decoded from the next state so they are registered
      // and line up exactly with the state they belong to.
      busy_d        = (state_d != S_IDLE) && (state_d != S_ERR);
      sol_enable_d  = (state_d != S_ERR);
      sol_trigger_d = (state_d == S_TRIG);
      sol_load_d    = (state_d == S_LOAD);
      sol_upd_d     = (state_d == S_PARAM);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         timer_q       <= '0;
         wd_q          <= '0;
         stop_seen_q   <= 1'b0;
         step_cnt_q    <= '0;
         snap_id_q     <= '0;
         snap_iq_q     <= '0;
         snap_omega_q  <= '0;
         snap_theta_q  <= '0;
         snap_valid_q  <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         busy_q        <= 1'b0;
         sol_enable_q  <= 1'b0;
         sol_trigger_q <= 1'b0;
         sol_load_q    <= 1'b0;
         sol_upd_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         wd_q          <= wd_d;
         stop_seen_q   <= stop_seen_d;
         step_cnt_q    <= step_cnt_d;
         snap_id_q     <= snap_id_d;
         snap_iq_q     <= snap_iq_d;
         snap_omega_q  <= snap_omega_d;
         snap_theta_q  <= snap_theta_d;
         snap_valid_q  <= snap_valid_d;
         done_q        <= done_d;
         error_q       <= error_d;
         busy_q        <= busy_d;
         sol_enable_q  <= sol_enable_d;
         sol_trigger_q <= sol_trigger_d;
         sol_load_q    <= sol_load_d;
         sol_upd_q     <= sol_upd_d;
      end
   end

   assign busy                 = busy_q;
   assign done                 = done_q;
   assign error                = error_q;
   assign step_cnt             = step_cnt_q;
   assign snap_id              = snap_id_q;
   assign snap_iq              = snap_iq_q;
   assign snap_omega           = snap_omega_q;
   assign snap_theta           = snap_theta_q;
   assign snap_valid           = snap_valid_q;
   assign sol.sol_enable       = sol_enable_q;
   assign sol.sol_trigger      = sol_trigger_q;
   assign sol.sol_load         = sol_load_q;
   assign sol.sol_update_param = sol_upd_q;

endmodule

// File: tb/tb_pmsm_solver_sequencer.sv
// Directed/randomized bench for pmsm_solver_sequencer with a latency-based
// solver model and arithmetic expectations for trigger/snapshot timing.
module tb_pmsm_solver_sequencer;
   localparam int W       = 35;
   localparam int TIMER_W = 16;
   localparam int TIMEOUT = 64;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0, stop = 1'b0, load_req = 1'b0;
   logic                param_req = 1'b0, clr_err = 1'b0;
   logic [TIMER_W-1:0]  period = '0;
   logic [31:0]         n_steps = '0;
   logic                busy, done, error, snap_valid;
   logic [31:0]         step_cnt;
   logic signed [W-1:0] snap_id, snap_iq, snap_omega, snap_theta;

   pmsm_solver_sequencer_if #(.W(W)) sif ();

   pmsm_solver_sequencer #(.W(W), .TIMER_W(TIMER_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load_req(load_req),
      .param_req(param_req), .clr_err(clr_err), .period(period), .n_steps(n_steps),
      .busy(busy), .done(done), .error(error), .step_cnt(step_cnt), .sol(sif),
      .snap_id(snap_id), .snap_iq(snap_iq), .snap_omega(snap_omega),
      .snap_theta(snap_theta), .snap_valid(snap_valid)
   );

   always #5 clk = ~clk;

   int total = 0;
   int fails = 0;

   // solver model controls and per-step result data
   int  lat = 4;
   int  rem = 0;
   int  vcount = 0;
   bit  valid_en = 1'b1;
   bit  ready_en = 1'b1;
   bit  upd_prev = 1'b0;
   logic signed [W-1:0] d_id[8], d_iq[8], d_om[8], d_th[8];

   function automatic logic signed [W-1:0] rnd_w();
      return W'({$urandom(), $urandom()});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill_data();
      for (int i = 0; i < 8; i++) begin
         d_id[i] = rnd_w();
         d_iq[i] = rnd_w();
         d_om[i] = rnd_w();
         d_th[i] = rnd_w();
      end
   endtask

   // Solver: valid arrives after `lat` idle cycles following a trigger;
   // param_ready echoes update_param one cycle late; outputs carry junk otherwise.
   initial begin
      sif.sol_valid       = 1'b0;
      sif.sol_param_ready = 1'b0;
      sif.sol_id = '0; sif.sol_iq = '0; sif.sol_omega = '0; sif.sol_theta = '0;
      forever begin
         tick();
         sif.sol_param_ready = ready_en && upd_prev;
         upd_prev            = sif.sol_update_param;
         sif.sol_valid       = 1'b0;
         sif.sol_id = rnd_w(); sif.sol_iq = rnd_w();
         sif.sol_omega = rnd_w(); sif.sol_theta = rnd_w();
         if (!rst_n) begin
            rem = 0;
         end else begin
            if (rem > 0) begin
               rem--;
               if (rem == 0 && valid_en) begin
                  sif.sol_valid = 1'b1;
                  sif.sol_id    = d_id[vcount % 8];
                  sif.sol_iq    = d_iq[vcount % 8];
                  sif.sol_omega = d_om[vcount % 8];
                  sif.sol_theta = d_th[vcount % 8];
                  vcount++;
               end
            end
            if (sif.sol_trigger) rem = lat + 1;
         end
      end
   end

   // Counted run: triggers at 1+P, then every L+2+P; snapshot L+2 after each trigger.
   task automatic run_counted(input int p, input int l, input int n);
      int  peff, t1, iv, last, k;
      bit  is_trig, is_snap;
      peff = (p == 0) ? 1 : p;
      iv   = l + 2 + peff;
      t1   = 1 + peff;
      last = t1 + (n - 1) * iv + l + 2;
      period = TIMER_W'(p); n_steps = 32'(n); lat = l; valid_en = 1'b1; vcount = 0;
      start = 1'b1; tick(); start = 1'b0;
      for (int r = 1; r <= last + 3; r++) begin
         is_trig = (r >= t1) && ((r - t1) % iv == 0) && ((r - t1) / iv < n);
         is_snap = (r >= t1 + l + 2) && ((r - t1 - l - 2) % iv == 0) && ((r - t1 - l - 2) / iv < n);
         k = is_snap ? (r - t1 - l - 2) / iv : 0;
         chk("run_trigger", sif.sol_trigger, is_trig);
         chk("run_snap_valid", snap_valid, is_snap);
         chk("run_done", done, is_snap && (k == n - 1));
         if (is_snap) begin
            chk("run_snap_id", snap_id, d_id[k]);
            chk("run_snap_iq", snap_iq, d_iq[k]);
            chk("run_snap_omega", snap_omega, d_om[k]);
            chk("run_snap_theta", snap_theta, d_th[k]);
            chk("run_step_cnt", step_cnt, k + 1);
         end
         tick();
      end
      chk("run_busy_end", busy, 1'b0);
      chk("run_step_cnt_end", step_cnt, n);
   endtask

   initial begin
      int l;
      fill_data();
      // reset state
      tick(); tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_step_cnt", step_cnt, 0);
      chk("rst_enable", sif.sol_enable, 1'b0);
      chk("rst_trigger", sif.sol_trigger, 1'b0);
      chk("rst_load", sif.sol_load, 1'b0);
      chk("rst_upd", sif.sol_update_param, 1'b0);
      chk("rst_snap_valid", snap_valid, 1'b0);
      chk("rst_snap_id", snap_id, 0);
      #2 rst_n = 1'b1;
      tick();
      chk("idle_enable", sif.sol_enable, 1'b1);

      // load
      load_req = 1'b1; tick(); load_req = 1'b0;
      chk("load_pulse", sif.sol_load, 1'b1);
      chk("load_busy", busy, 1'b1);
      chk("load_trig", sif.sol_trigger, 1'b0);
      tick();
      chk("load_end", sif.sol_load, 1'b0);
      chk("load_busy_end", busy, 1'b0);
      chk("load_trig_end", sif.sol_trigger, 1'b0);

      // param with one-cycle response
      param_req = 1'b1; tick(); param_req = 1'b0;
      chk("param_upd1", sif.sol_update_param, 1'b1);
      tick();
      chk("param_upd2", sif.sol_update_param, 1'b1);
      tick();
      chk("param_upd_end", sif.sol_update_param, 1'b0);
      chk("param_busy_end", busy, 1'b0);
      chk("param_error", error, 1'b0);

      // param watchdog: 65 unanswered cycles, then ERR
      ready_en = 1'b0;
      param_req = 1'b1; tick(); param_req = 1'b0;
      for (int r = 1; r <= 66; r++) begin
         chk("pwd_error", error, r >= 66);
         chk("pwd_enable", sif.sol_enable, r < 66);
         chk("pwd_upd", sif.sol_update_param, r < 66);
         tick();
      end
      ready_en = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      chk("err_start_busy", busy, 1'b0);
      chk("err_start_error", error, 1'b1);
      chk("err_trigger", sif.sol_trigger, 1'b0);
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      chk("clr_error", error, 1'b0);
      chk("clr_enable", sif.sol_enable, 1'b1);

      // reference run, then randomized counted runs
      fill_data();
      d_id[0] = 35'sh7_0000_0001;
      run_counted(10, 25, 3);
      for (int i = 0; i < 4; i++) begin
         fill_data();
         run_counted(int'($urandom_range(0, 6)), int'($urandom_range(1, 10)), int'($urandom_range(1, 4)));
      end

      // free-run, stop during WAIT_VALID completes the step only
      fill_data();
      l = int'($urandom_range(8, 15));
      period = '0; n_steps = '0; lat = l; vcount = 0;
      start = 1'b1; tick(); start = 1'b0;
      for (int r = 1; r <= l + 24; r++) begin
         chk("fr_trigger", sif.sol_trigger, r == 2);
         chk("fr_snap_valid", snap_valid, r == l + 4);
         chk("fr_busy", busy, r < l + 4);
         chk("fr_done", done, 1'b0);
         if (r == l + 4) begin
            chk("fr_snap_id", snap_id, d_id[0]);
            chk("fr_step_cnt", step_cnt, 1);
         end
         stop = (r == 5);
         tick();
      end
      stop = 1'b0;

      // coincident requests: start wins; stop in WAIT_TICK issues no trigger
      period = TIMER_W'(20);
      start = 1'b1; param_req = 1'b1; load_req = 1'b1; tick();
      start = 1'b0; param_req = 1'b0; load_req = 1'b0;
      for (int r = 1; r <= 30; r++) begin
         chk("co_load", sif.sol_load, 1'b0);
         chk("co_upd", sif.sol_update_param, 1'b0);
         chk("co_trigger", sif.sol_trigger, 1'b0);
         chk("co_busy", busy, r <= 5);
         stop = (r == 5);
         tick();
      end
      stop = 1'b0;
      chk("co_step_cnt", step_cnt, 0);

      // WAIT_VALID watchdog
      valid_en = 1'b0;
      period = TIMER_W'(1); n_steps = 32'd2; lat = 4;
      start = 1'b1; tick(); start = 1'b0;
      for (int r = 1; r <= 68; r++) begin
         chk("vwd_trigger", sif.sol_trigger, r == 2);
         chk("vwd_error", error, r >= 68);
         chk("vwd_enable", sif.sol_enable, r < 68);
         tick();
      end
      valid_en = 1'b1;
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      chk("vwd_clr", error, 1'b0);

      // async reset mid WAIT_VALID
      fill_data();
      period = TIMER_W'(2); n_steps = '0; lat = 30;
      start = 1'b1; tick(); start = 1'b0;
      for (int r = 1; r <= 10; r++) begin
         chk("ar_trigger", sif.sol_trigger, r == 3);
         tick();
      end
      chk("ar_busy_before", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_busy", busy, 1'b0);
      chk("ar_enable", sif.sol_enable, 1'b0);
      chk("ar_trigger0", sif.sol_trigger, 1'b0);
      chk("ar_step_cnt", step_cnt, 0);
      chk("ar_snap_id", snap_id, 0);
      chk("ar_snap_theta", snap_theta, 0);
      chk("ar_error", error, 1'b0);
      tick(); tick();
      #2 rst_n = 1'b1;
      tick();
      for (int r = 1; r <= 50; r++) begin
         chk("ar_no_trigger", sif.sol_trigger, 1'b0);
         chk("ar_idle", busy, 1'b0);
         chk("ar_snap_valid", snap_valid, 1'b0);
         tick();
      end

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule

// File: doc/pmsm_solver_sequencer.md
# pmsm_solver_sequencer

Host-side initiator for the PMSM state solver: drives the solver's enable/load/update_param/trigger controls, paces integration steps from a programmable period timer, and waits for each step's valid. On each valid it captures the id/iq/omega/theta state into snapshot registers. A watchdog catches a solver that never answers. The block sits between the HIL host register bank and the solver instance.

## Interface
Parameters:
- W, 35, state word width (signed)
- TIMER_W, 16, period timer width
- TIMEOUT, 64, max cycles waited for sol_valid or sol_param_ready

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse: begin stepping
- stop  in  1  pulse/level: halt after current step
- load_req  in  1  pulse: load initial state into solver
- param_req  in  1  pulse: commit solver parameters
- clr_err  in  1  pulse: leave ERR
- period  in  TIMER_W  idle cycles before each trigger (0 treated as 1)
- n_steps  in  32  step count per run; 0 = free-run
- busy  out  1  state not IDLE/ERR
- done  out  1  one-cycle pulse at end of counted run
- error  out  1  sticky timeout flag
- step_cnt  out  32  completed steps in current run
- sol_enable  out  1  to solver enable
- sol_trigger  out  1  to solver trigger
- sol_load  out  1  to solver load
- sol_update_param  out  1  to solver update_param
- sol_param_ready  in  1  from solver
- sol_valid  in  1  from solver
- sol_id, sol_iq, sol_omega, sol_theta  in  W each  solver state (signed)
- snap_id, snap_iq, snap_omega, snap_theta  out  W each  captured state
- snap_valid  out  1  one-cycle pulse, snapshot updated

## Operation
- All outputs registered. Reset values: every output 0, state IDLE.
- States: IDLE, LOAD, PARAM, WAIT_TICK, TRIG, WAIT_VALID, ERR.
- sol_enable = 1 in every state except ERR (and reset).
- IDLE priority when requests coincide: start > param_req > load_req. Requests outside IDLE are ignored (not queued).
- LOAD: sol_load = 1 for exactly one cycle, sol_trigger = 0, then IDLE.
- PARAM: sol_update_param held at 1 until sol_param_ready sampled high; then deassert and return to IDLE. Watchdog > TIMEOUT cycles -> ERR.
- start: step_cnt <= 0, timer <= max(period,1), go to WAIT_TICK.
- WAIT_TICK: timer decrements each cycle. On reaching 1 -> TRIG. stop -> IDLE, with no trigger issued.
- TRIG: sol_trigger = 1 for exactly one cycle (never two consecutive cycles, since the solver restarts on a held trigger). Watchdog cleared. Then WAIT_VALID.
- WAIT_VALID, on sol_valid:
  - Latch sol_* into snap_*, pulse snap_valid, step_cnt += 1.
  - If n_steps != 0 and new step_cnt == n_steps: pulse done, go to IDLE.
  - Else if stop seen (stop is latched while in TRIG/WAIT_VALID): go to IDLE.
  - Else reload timer and go to WAIT_TICK.
- WAIT_VALID watchdog: count exceeds TIMEOUT with no sol_valid -> ERR. A stop in WAIT_VALID never aborts an in-flight step.
- ERR: error = 1, sol_enable = 0 (aborts solver pipeline), all other sol_* = 0. clr_err -> error = 0, go to IDLE. start in ERR is ignored.
- step_cnt wraps 0xFFFFFFFF -> 0 in free-run, with no flag. Snapshot regs hold their value until the next valid.
- rst_n low at any time: immediate return to reset values, including mid-step. The solver is also reset by its own sol_enable = 0.

## Timing
- start sampled at edge k -> WAIT_TICK from k+1. The first sol_trigger is high for cycle k+1+max(period,1).
- sol_valid sampled at edge v -> snap_* and snap_valid (and done, if applicable) visible after edge v. The next trigger follows max(period,1) cycles later.
- Trigger-to-trigger interval = solver latency + 2 + max(period,1).
- load_req at edge k -> sol_load high for cycle k+1 only.
- param_req at edge k -> sol_update_param high from k+1 through the cycle sol_param_ready is sampled.
- Watchdog counts from the cycle after TRIG (or PARAM entry). ERR is entered on count TIMEOUT+1.

## Test plan
- Reset, then load_req with solver idle -> exactly one sol_load cycle, sol_trigger = 0 throughout, busy returns to 0 after 2 cycles.
- param_req, solver responds after 1 cycle -> sol_update_param high 2 cycles, error = 0. Separately, model never answers -> error = 1 and sol_enable = 0 after 65 cycles; clr_err restores sol_enable = 1.
- period = 10, n_steps = 3, model valid 25 cycles after trigger -> three single-cycle triggers 37 cycles apart, three snap_valid pulses with snapshots matching the model (e.g. id = 35'sh7_0000_0001), done on the third, step_cnt = 3.
- Free-run, period = 0, stop asserted mid WAIT_VALID -> current step completes (snap_valid pulse), no further trigger, state IDLE.
- start, param_req and load_req in the same IDLE cycle -> run starts; no sol_load and no sol_update_param issued.
- rst_n dropped in WAIT_VALID -> all outputs 0 asynchronously. After release, no trigger is issued until a new start.
